// File: rtl/chnl_rx_slave.sv
// Receive-side channel endpoint: valid/ready write port into a first-word-fall-through FIFO,
// drained by the downstream arbiter through a request/grant handshake.
module chnl_rx_slave #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DW-1:0]    ch_data_i,
    input  logic             ch_valid_i,
    output logic             ch_ready_o,
    output logic [5:0]       ch_margin_o,
    output logic             a_req_o,
    output logic [DW-1:0]    a_data_o,
    input  logic             a_gnt_i,
    output logic [CNT_W-1:0] rx_cnt_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] DepthC   = DEPTH[AW:0];
    localparam logic [AW:0] LastPtr  = DEPTH[AW:0] - 1'b1;
    localparam logic [5:0]  DepthM   = DEPTH[5:0];

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [DW-1:0]    r_mem [DEPTH];

    logic        w_push;
    logic        w_pop;
    logic        w_not_full;
    logic        w_not_empty;
    logic [AW:0] w_wptr_nxt;
    logic [AW:0] w_rptr_nxt;
    logic        w_unused_msb;

    assign w_not_full  = (r_count < DepthC);
    assign w_not_empty = (r_count != '0);

    // Ready is gated by reset directly so the initiator sees it drop asynchronously.
    assign ch_ready_o  = w_not_full && !rstn;
    assign w_push      = ch_valid_i && ch_ready_o;
    assign w_pop       = a_gnt_i && w_not_empty;

    // Pointers wrap modulo DEPTH, so their top bit never sets; it is kept for width symmetry.
    assign w_wptr_nxt   = (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt   = (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
    assign w_unused_msb = r_wptr[AW] ^ r_rptr[AW];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr   <= w_wptr_nxt;
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= ch_data_i;
        end
    end

    assign ch_margin_o = DepthM - 6'(r_count);
    assign a_req_o     = w_not_empty;
    assign a_data_o    = w_not_empty ? r_mem[r_rptr[AW-1:0]] : '0;
    assign rx_cnt_o    = r_rx_cnt;

endmodule

// File: tb/tb_chnl_rx_slave.sv
// Scoreboard bench for chnl_rx_slave: stimulus queues expected pops, a monitor compares
// every granted head word, and status outputs are checked against hand-computed values.
module tb_chnl_rx_slave;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic [DW-1:0]    ch_data_i = '0;
    logic             ch_valid_i = 1'b0;
    logic             ch_ready_o;
    logic [5:0]       ch_margin_o;
    logic             a_req_o;
    logic [DW-1:0]    a_data_o;
    logic             a_gnt_i = 1'b0;
    logic [CNT_W-1:0] rx_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_rx = 0;
    logic [DW-1:0] sb_q[$];

    chnl_rx_slave #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ch_data_i   (ch_data_i),
        .ch_valid_i  (ch_valid_i),
        .ch_ready_o  (ch_ready_o),
        .ch_margin_o (ch_margin_o),
        .a_req_o     (a_req_o),
        .a_data_o    (a_data_o),
        .a_gnt_i     (a_gnt_i),
        .rx_cnt_o    (rx_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input logic rdy, input int margin,
                              input logic req, input logic [DW-1:0] head);
        chk({name, "_ready"}, 64'(ch_ready_o), 64'(rdy));
        chk({name, "_margin"}, 64'(ch_margin_o), 64'(margin));
        chk({name, "_req"}, 64'(a_req_o), 64'(req));
        chk({name, "_head"}, 64'(a_data_o), 64'(head));
        chk({name, "_rxcnt"}, 64'(rx_cnt_o), 64'(exp_rx % 65536));
    endtask

    // Pops the scoreboard whenever a grant meets a request, checked mid-cycle.
    task automatic monitor();
        logic [DW-1:0] exp;
        forever begin
            @(negedge clk);
            if (rstn === 1'b0 && a_req_o === 1'b1 && a_gnt_i === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual=%0h required=none", a_data_o);
                end else begin
                    exp = sb_q.pop_front();
                    chk("pop_data", 64'(a_data_o), 64'(exp));
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        ch_valid_i = 1'b1;
        ch_data_i  = d;
        sb_q.push_back(d);
        exp_rx++;
        cyc();
        ch_valid_i = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (10) @(posedge clk);
        #1;
        chk_status("reset", 1'b0, 32, 1'b0, 32'h0);
        rstn = 1'b0;
        #1;
        chk("release_ready", 64'(ch_ready_o), 64'd1);

        // Single word, no same-cycle bypass
        push(32'h1000_0005);
        chk_status("single", 1'b1, 31, 1'b1, 32'h1000_0005);
        a_gnt_i = 1'b1;
        cyc();
        a_gnt_i = 1'b0;
        chk_status("single_pop", 1'b1, 32, 1'b0, 32'h0);

        // Fill to full, then offer a word that must be dropped
        for (int i = 0; i < DEPTH; i++) push(32'(i));
        chk_status("full", 1'b0, 0, 1'b1, 32'h0);
        ch_valid_i = 1'b1;
        ch_data_i  = 32'h0000_DEAD;
        cyc();
        ch_valid_i = 1'b0;
        chk_status("full_drop", 1'b0, 0, 1'b1, 32'h0);
        a_gnt_i = 1'b1;
        repeat (DEPTH) cyc();
        a_gnt_i = 1'b0;
        chk_status("drained", 1'b1, 32, 1'b0, 32'h0);

        // Streaming: grant on empty is ignored on the first cycle, then one-in one-out
        ch_valid_i = 1'b1;
        a_gnt_i    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ch_data_i = 32'h2000_0000 + 32'(i);
            sb_q.push_back(ch_data_i);
            exp_rx++;
            cyc();
            chk("stream_margin", 64'(ch_margin_o), 64'd31);
        end
        ch_valid_i = 1'b0;
        chk("stream_head", 64'(a_data_o), 64'h2000_0063);
        cyc();
        a_gnt_i = 1'b0;
        chk_status("stream_end", 1'b1, 32, 1'b0, 32'h0);

        // Full with a pop: ready returns only after the popping edge
        for (int i = 0; i < DEPTH; i++) push(32'h3000_0000 + 32'(i));
        chk_status("full2", 1'b0, 0, 1'b1, 32'h3000_0000);
        a_gnt_i = 1'b1;
        cyc();
        a_gnt_i = 1'b0;
        chk_status("full_pop", 1'b1, 1, 1'b1, 32'h3000_0001);
        push(32'h3000_00FF);
        chk_status("refill", 1'b0, 0, 1'b1, 32'h3000_0001);
        a_gnt_i = 1'b1;
        repeat (DEPTH) cyc();
        a_gnt_i = 1'b0;
        chk_status("drained2", 1'b1, 32, 1'b0, 32'h0);

        // Mid-stream reset discards buffered words immediately
        for (int i = 0; i < 10; i++) push(32'h4000_0000 + 32'(i));
        chk("pre_reset_margin", 64'(ch_margin_o), 64'd22);
        rstn = 1'b1;
        #1;
        sb_q.delete();
        exp_rx = 0;
        chk_status("mid_reset", 1'b0, 32, 1'b0, 32'h0);
        cyc();
        rstn = 1'b0;
        #1;
        push(32'h0000_0007);
        chk_status("post_reset", 1'b1, 31, 1'b1, 32'h0000_0007);
        a_gnt_i = 1'b1;
        cyc();
        a_gnt_i = 1'b0;
        chk_status("final", 1'b1, 32, 1'b0, 32'h0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
